instr_mem_prog: RTL and testbench
=================================

INSTR_MEM_PROG -- requirements
Module: instr_mem_prog

Interface
REQ-001 Parameter DEPTH, default 256, number of instruction words.
REQ-002 Parameter IW, default 9, instruction width in bits.
REQ-003 Parameter AW, default $clog2(DEPTH), address width.
REQ-004 Parameter NOP, default 0 (IW bits), word returned on invalid fetch.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 load_start  in  1  enter LOAD state; clear write pointer and program length.
REQ-008 load_valid  in  1  load_data is valid this cycle.
REQ-009 load_data  in  IW  instruction word to store.
REQ-010 load_done  in  1  end of program image.
REQ-011 fetch_req  in  1  fetch request.
REQ-012 fetch_addr  in  AW  fetch address.
REQ-013 stall  in  1  consumer not ready; hold fetch outputs.
REQ-014 instr_out  out  IW  fetched instruction (registered).
REQ-015 instr_valid  out  1  instr_out holds a valid fetch result.
REQ-016 fault  out  1  bad fetch address or load overflow, one result/cycle.
REQ-017 prog_len  out  AW+1  number of words loaded.
REQ-018 ready  out  1  high only in RUN state.

Function
REQ-019 States EMPTY, LOAD, RUN; storage is DEPTH x IW synchronous-write memory.
REQ-020 load_start in any state -> LOAD next cycle; wptr=0, prog_len=0; load_start has priority over load_done and fetch_req.
REQ-021 LOAD, load_valid, wptr<DEPTH -> mem[wptr]=load_data, wptr+1, prog_len+1.
REQ-022 LOAD, load_valid, wptr==DEPTH -> write dropped, fault=1 next cycle for one cycle, prog_len unchanged.
REQ-023 LOAD, load_done -> RUN if resulting prog_len>0, else EMPTY; same-cycle load_valid is written first.
REQ-024 EMPTY/LOAD: fetch_req ignored; instr_valid=0; instr_out holds.
REQ-025 RUN, fetch_req, !stall -> next cycle instr_valid=1, instr_out=mem[fetch_addr]; latency exactly 1 cycle.
REQ-026 RUN fetch with fetch_addr>=prog_len -> instr_out=NOP, instr_valid=1, fault=1 for that result.
REQ-027 stall=1 -> instr_out, instr_valid, fault all hold; fetch_req that cycle is not accepted.
REQ-028 !stall, !fetch_req -> instr_valid=0, fault=0, instr_out holds.
REQ-029 Back-to-back accepted fetches give one result per cycle, in order.
REQ-030 ready=1 exactly when state is RUN; leaving RUN via load_start drops ready next cycle and any pending result is discarded (instr_valid=0).

Reset
REQ-031 rst_n low -> immediately: state EMPTY, wptr=0, prog_len=0, instr_out=NOP, instr_valid=0, fault=0, ready=0.
REQ-032 Memory contents are not reset; after reset only reloaded words are readable (prog_len=0 makes every fetch invalid).
REQ-033 Reset asserted mid-LOAD or mid-RUN aborts the operation; no partial write completes after rst_n deasserts.

Verification
REQ-034 Load 33 words (word i = i+1), load_done -> prog_len=33, ready=1; fetch addr 0..32 back-to-back -> instr_out 1..33, instr_valid=1 every cycle, fault=0.
REQ-035 After REQ-034 load, fetch addr 40 -> instr_out=NOP, instr_valid=1, fault=1; next fetch addr 5 -> instr_out=6, fault=0.
REQ-036 DEPTH=4: load 5 words -> 5th dropped, fault pulse 1 cycle, prog_len=4; fetch addr 3 -> word 4.
REQ-037 Fetch addr 2 then stall=1 for 3 cycles with fetch_req=1 addr 7 -> instr_out=mem[2], instr_valid=1 held 3 cycles; stall release -> mem[7] next cycle.
REQ-038 rst_n pulsed low mid-load after 10 words -> all outputs at reset values immediately, ready=0; fetch_req ignored until new load completes.
REQ-039 load_start then load_done with no load_valid -> state EMPTY, ready=0, prog_len=0.

Source files
------------

// File: rtl/instr_mem_prog.sv
// Loadable instruction store: EMPTY/LOAD/RUN control with a
// registered single-cycle fetch port and overflow/bad-address fault.
module instr_mem_prog #(
  parameter int              DEPTH = 256,
  parameter int              IW    = 9,
  parameter int              AW    = $clog2(DEPTH),
  parameter logic [IW-1:0]   NOP   = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_done,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  input  logic          stall,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  output logic          fault,
  output logic [AW:0]   prog_len,
  output logic          ready
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_LOAD,
    S_RUN
  } state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [IW-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   len_q, len_d;
  logic [IW-1:0] out_q, out_d;
  logic          valid_q, valid_d;
  logic          fault_q, fault_d;
  logic          ready_q, ready_d;

  logic          we;
  logic [IW-1:0] rd_word;
  logic          in_range;

  assign rd_word  = mem[fetch_addr];
  assign in_range = {1'b0, fetch_addr} < len_q;

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    len_d   = len_q;
    out_d   = out_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    we      = 1'b0;
    if (load_start) begin
      state_d = S_LOAD;
      wptr_d  = '0;
      len_d   = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (load_valid) begin
            if (wptr_q != DEPTH_C) begin
              we     = 1'b1;
              wptr_d = wptr_q + 1'b1;
              len_d  = len_q + 1'b1;
            end else begin
              fault_d = 1'b1;
            end
          end
          // Same-cycle word already counted in len_d
          if (load_done) begin
            state_d = (len_d != '0) ? S_RUN : S_EMPTY;
          end
        end
        S_RUN: begin
          if (stall) begin
            valid_d = valid_q;
            fault_d = fault_q;
          end else if (fetch_req) begin
            valid_d = 1'b1;
            if (in_range) begin
              out_d = rd_word;
            end else begin
              out_d   = NOP;
              fault_d = 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
    ready_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      wptr_q  <= '0;
      len_q   <= '0;
      out_q   <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      ready_q <= ready_d;
    end
  end

  // Storage is not reset; prog_len gates what is readable
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wptr_q[AW-1:0]] <= load_data;
    end
  end

  assign instr_out   = out_q;
  assign instr_valid = valid_q;
  assign fault       = fault_q;
  assign prog_len    = len_q;
  assign ready       = ready_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Directed bench for instr_mem_prog: default instance plus a
// DEPTH=4 instance for the overflow path.
module tb_instr_mem_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start, load_valid, load_done;
  logic [8:0] load_data;
  logic       fetch_req, stall;
  logic [7:0] fetch_addr;
  logic [8:0] instr_out;
  logic       instr_valid, fault, ready;
  logic [8:0] prog_len;

  logic       s_load_start, s_load_valid, s_load_done;
  logic [8:0] s_load_data;
  logic       s_fetch_req, s_stall;
  logic [1:0] s_fetch_addr;
  logic [8:0] s_instr_out;
  logic       s_instr_valid, s_fault, s_ready;
  logic [2:0] s_prog_len;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_mem_prog dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_done(load_done),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .stall(stall), .instr_out(instr_out),
    .instr_valid(instr_valid), .fault(fault),
    .prog_len(prog_len), .ready(ready)
  );

  instr_mem_prog #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_start(s_load_start), .load_valid(s_load_valid),
    .load_data(s_load_data), .load_done(s_load_done),
    .fetch_req(s_fetch_req), .fetch_addr(s_fetch_addr),
    .stall(s_stall), .instr_out(s_instr_out),
    .instr_valid(s_instr_valid), .fault(s_fault),
    .prog_len(s_prog_len), .ready(s_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in;
    load_start = 0; load_valid = 0; load_done = 0;
    load_data = '0; fetch_req = 0; stall = 0; fetch_addr = '0;
    s_load_start = 0; s_load_valid = 0; s_load_done = 0;
    s_load_data = '0; s_fetch_req = 0; s_stall = 0;
    s_fetch_addr = '0;
  endtask

  task automatic load_prog(input int n, input int base);
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1; load_data = 9'(base + i); tick();
    end
    load_valid = 0; load_done = 1; tick(); load_done = 0;
  endtask

  task automatic test_reset;
    rst_n = 0; clr_in(); #2;
    n_chk++;
    if ({instr_out, instr_valid, fault, ready} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outs got %h/%b/%b/%b exp 0/0/0/0",
               instr_out, instr_valid, fault, ready);
    end
    n_chk++;
    if (prog_len !== 9'd0 || s_prog_len !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_len got %0d/%0d exp 0/0", prog_len, s_prog_len);
    end
    @(negedge clk); rst_n = 1; tick();
  endtask

  task automatic test_load_fetch;
    load_prog(33, 1);
    n_chk++;
    if (prog_len !== 9'd33 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load33 got len %0d rdy %b exp 33 1", prog_len, ready);
    end
    for (int i = 0; i < 33; i++) begin
      fetch_req = 1; fetch_addr = 8'(i); tick();
      n_chk++;
      if ({instr_out, instr_valid, fault} !== {9'(i + 1), 2'b10}) begin
        n_fail++;
        $display("FAIL b2b_%0d got %0d/%b/%b exp %0d/1/0",
                 i, instr_out, instr_valid, fault, i + 1);
      end
    end
    fetch_req = 0; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd33, 2'b00}) begin
      n_fail++;
      $display("FAIL idle got %0d/%b/%b exp 33/0/0",
               instr_out, instr_valid, fault);
    end
  endtask

  task automatic test_bad_addr;
    fetch_req = 1; fetch_addr = 8'd40; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL bad40 got %0d/%b/%b exp 0/1/1",
               instr_out, instr_valid, fault);
    end
    fetch_addr = 8'd5; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd6, 2'b10}) begin
      n_fail++;
      $display("FAIL after_bad got %0d/%b/%b exp 6/1/0",
               instr_out, instr_valid, fault);
    end
    fetch_addr = 8'd33; tick();
    stall = 1; fetch_addr = 8'd5; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL stall_fault got %0d/%b/%b exp 0/1/1",
               instr_out, instr_valid, fault);
    end
    stall = 0; fetch_req = 0; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd0, 2'b00}) begin
      n_fail++;
      $display("FAIL clr_fault got %0d/%b/%b exp 0/0/0",
               instr_out, instr_valid, fault);
    end
  endtask

  task automatic test_stall;
    fetch_req = 1; fetch_addr = 8'd2; tick();
    stall = 1; fetch_addr = 8'd7;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({instr_out, instr_valid, fault} !== {9'd3, 2'b10}) begin
        n_fail++;
        $display("FAIL stall_%0d got %0d/%b/%b exp 3/1/0",
                 i, instr_out, instr_valid, fault);
      end
    end
    stall = 0; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd8, 2'b10}) begin
      n_fail++;
      $display("FAIL unstall got %0d/%b/%b exp 8/1/0",
               instr_out, instr_valid, fault);
    end
    fetch_req = 0; tick();
  endtask

  task automatic test_leave_run;
    fetch_req = 1; fetch_addr = 8'd0; load_start = 1; tick();
    load_start = 0; fetch_req = 0;
    n_chk++;
    if ({instr_out, instr_valid, ready} !== {9'd8, 2'b00}) begin
      n_fail++;
      $display("FAIL leave_run got %0d/%b/%b exp 8/0/0",
               instr_out, instr_valid, ready);
    end
  endtask

  task automatic test_empty_load;
    load_done = 1; tick(); load_done = 0;
    n_chk++;
    if (ready !== 1'b0 || prog_len !== 9'd0) begin
      n_fail++;
      $display("FAIL empty_load got rdy %b len %0d exp 0 0", ready, prog_len);
    end
    fetch_req = 1; fetch_addr = 8'd0; tick(); fetch_req = 0;
    n_chk++;
    if (instr_valid !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_fetch got v %b rdy %b exp 0 0",
               instr_valid, ready);
    end
  endtask

  task automatic test_done_with_valid;
    load_start = 1; tick(); load_start = 0;
    load_valid = 1; load_data = 9'h1AB; load_done = 1; tick();
    load_valid = 0; load_done = 0;
    n_chk++;
    if (prog_len !== 9'd1 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL done_valid got len %0d rdy %b exp 1 1", prog_len, ready);
    end
    fetch_req = 1; fetch_addr = 8'd1; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL len1_bad got %0h/%b/%b exp 0/1/1",
               instr_out, instr_valid, fault);
    end
    fetch_addr = 8'd0; tick(); fetch_req = 0;
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'h1AB, 2'b10}) begin
      n_fail++;
      $display("FAIL len1_ok got %0h/%b/%b exp 1ab/1/0",
               instr_out, instr_valid, fault);
    end
    tick();
  endtask

  task automatic test_reset_mid_load;
    load_start = 1; tick(); load_start = 0;
    for (int i = 0; i < 10; i++) begin
      load_valid = 1; load_data = 9'(100 + i); tick();
    end
    n_chk++;
    if (prog_len !== 9'd10) begin
      n_fail++;
      $display("FAIL mid_len got %0d exp 10", prog_len);
    end
    #2 rst_n = 0; #1;
    n_chk++;
    if ({instr_out, instr_valid, fault, ready, prog_len} !==
        {9'd0, 3'b000, 9'd0}) begin
      n_fail++;
      $display("FAIL async_rst got %0h/%b/%b/%b/%0d exp 0/0/0/0/0",
               instr_out, instr_valid, fault, ready, prog_len);
    end
    clr_in();
    @(negedge clk); rst_n = 1;
    fetch_req = 1; fetch_addr = 8'd0; tick(); fetch_req = 0;
    n_chk++;
    if (instr_valid !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_fetch got v %b rdy %b exp 0 0",
               instr_valid, ready);
    end
    load_prog(3, 21);
    fetch_req = 1; fetch_addr = 8'd1; tick();
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd22, 2'b10}) begin
      n_fail++;
      $display("FAIL reload got %0d/%b/%b exp 22/1/0",
               instr_out, instr_valid, fault);
    end
    fetch_addr = 8'd5; tick(); fetch_req = 0;
    n_chk++;
    if ({instr_out, instr_valid, fault} !== {9'd0, 2'b11}) begin
      n_fail++;
      $display("FAIL stale got %0d/%b/%b exp 0/1/1",
               instr_out, instr_valid, fault);
    end
    tick();
  endtask

  task automatic test_overflow;
    s_load_start = 1; tick(); s_load_start = 0;
    for (int i = 0; i < 4; i++) begin
      s_load_valid = 1; s_load_data = 9'(10 + i); tick();
    end
    n_chk++;
    if (s_prog_len !== 3'd4 || s_fault !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_full got len %0d f %b exp 4 0", s_prog_len, s_fault);
    end
    s_load_data = 9'd14; tick();
    n_chk++;
    if (s_prog_len !== 3'd4 || s_fault !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop got len %0d f %b exp 4 1", s_prog_len, s_fault);
    end
    s_load_valid = 0; s_load_done = 1; tick(); s_load_done = 0;
    n_chk++;
    if ({s_fault, s_ready, s_prog_len} !== {2'b01, 3'd4}) begin
      n_fail++;
      $display("FAIL ovf_pulse got f %b rdy %b len %0d exp 0 1 4",
               s_fault, s_ready, s_prog_len);
    end
    s_fetch_req = 1; s_fetch_addr = 2'd3; tick();
    n_chk++;
    if ({s_instr_out, s_instr_valid, s_fault} !== {9'd13, 2'b10}) begin
      n_fail++;
      $display("FAIL ovf_a3 got %0d/%b/%b exp 13/1/0",
               s_instr_out, s_instr_valid, s_fault);
    end
    s_fetch_addr = 2'd0; tick(); s_fetch_req = 0;
    n_chk++;
    if ({s_instr_out, s_instr_valid, s_fault} !== {9'd10, 2'b10}) begin
      n_fail++;
      $display("FAIL ovf_a0 got %0d/%b/%b exp 10/1/0",
               s_instr_out, s_instr_valid, s_fault);
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_bad_addr();
    test_stall();
    test_leave_run();
    test_empty_load();
    test_done_with_valid();
    test_reset_mid_load();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
